// File: rtl/golden_nonce_tx_pkg.sv
// golden_nonce_tx_pkg: shared FSM state type and UART framing constants for the nonce transmitter
package golden_nonce_tx_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
    localparam int BITS_PER_BYTE   = 8;
    localparam int BYTES_PER_NONCE = 4;
    localparam int FRAME_BITS      = 10;
endpackage

// File: rtl/nonce_fifo.sv
// nonce_fifo: synchronous FIFO with head data visible combinationally
// Ports: clk/rst (sync active-high), push/din write, pop advances head,
//        dout = head word, full/empty flags, count = words queued.
module nonce_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      din,
    input  logic                  pop,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic do_push, do_pop;
    // Pointers carry one extra wrap bit: equal = empty, only MSB differs = full.
    always_comb begin
        empty    = wr_ptr_q == rd_ptr_q;
        full     = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
        count    = wr_ptr_q - rd_ptr_q;
        do_pop   = pop && !empty;
        // A pop on the same edge frees the slot being written, so full+pop still accepts.
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, do_pop};
        dout     = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= din;
    end
endmodule

// File: rtl/golden_nonce_uart_tx.sv
// golden_nonce_uart_tx: queues golden nonces and sends each as four 8N1 UART bytes, LSB byte first
// Ports: hash_clk, reset (sync active-high), golden_nonce_valid/golden_nonce strobe input,
//        tx_serial UART line (idle high), busy, sticky overflow, fifo_count words queued.
module golden_nonce_uart_tx
    import golden_nonce_tx_pkg::*;
#(
    parameter int BAUD_DIVISOR    = 434,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                     hash_clk,
    input  logic                     reset,
    input  logic                     golden_nonce_valid,
    input  logic [31:0]              golden_nonce,
    output logic                     tx_serial,
    output logic                     busy,
    output logic                     overflow,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count
);
    localparam int BW = $clog2(BAUD_DIVISOR);
    tx_state_e   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        overflow_q, overflow_d;
    logic        fifo_pop, fifo_full, fifo_empty, baud_last;
    logic [31:0] fifo_dout;

    nonce_fifo #(
        .WIDTH      (32),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk   (hash_clk),
        .rst   (reset),
        .push  (golden_nonce_valid),
        .din   (golden_nonce),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign fifo_pop  = (state_q == IDLE) && !fifo_empty;
    assign baud_last = baud_q == BW'(BAUD_DIVISOR - 1);

    // tx_d is the line level for the cycle after this edge, so tx_serial is a plain flop.
    // The shift word moves right once per data bit, so consecutive bytes fall out LSB first.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q + BW'(1);
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        overflow_d = overflow_q | (golden_nonce_valid & fifo_full & ~fifo_pop);
        case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (!fifo_empty) begin
                    state_d    = START;
                    shift_d    = fifo_dout;
                    byte_idx_d = '0;
                    tx_d       = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    state_d   = DATA;
                    baud_d    = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[31:1]};
                    if (bit_idx_q == 3'(BITS_PER_BYTE - 1)) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (byte_idx_q != 2'(BYTES_PER_NONCE - 1)) begin
                        state_d    = START;
                        byte_idx_d = byte_idx_q + 2'd1;
                        tx_d       = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_serial = tx_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// tb_golden_nonce_uart_tx: directed stimulus with a byte scoreboard fed by a UART decoder monitor
module tb_golden_nonce_uart_tx;
    logic        hash_clk = 1'b0;
    logic        reset = 1'b1;
    logic        golden_nonce_valid = 1'b0;
    logic [31:0] golden_nonce = '0;
    logic        tx_serial, busy, overflow;
    logic [2:0]  fifo_count;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    golden_nonce_uart_tx #(
        .BAUD_DIVISOR    (4),
        .FIFO_DEPTH_LOG2 (2)
    ) dut (
        .hash_clk           (hash_clk),
        .reset              (reset),
        .golden_nonce_valid (golden_nonce_valid),
        .golden_nonce       (golden_nonce),
        .tx_serial          (tx_serial),
        .busy               (busy),
        .overflow           (overflow),
        .fifo_count         (fifo_count)
    );

    always #5 hash_clk = ~hash_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge hash_clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] n, input bit sent);
        golden_nonce_valid = 1'b1;
        golden_nonce = n;
        if (sent) begin
            exp_q.push_back(8'h78 & 8'h00 | n[7:0]);
            exp_q.push_back(n[15:8]);
            exp_q.push_back(n[23:16]);
            exp_q.push_back(n[31:24]);
        end
        tick();
        golden_nonce_valid = 1'b0;
    endtask

    task automatic rst_dut();
        reset = 1'b1;
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (busy && n < 5000) begin
            tick();
            n++;
        end
        repeat (4) tick();
        chk({name, "_drained"}, {31'b0, busy}, 32'd0);
        chk({name, "_leftover"}, exp_q.size(), 32'd0);
    endtask

    // Decoder: start bit seen at t=0, mid-start at t=2, data bit i at t=6+4i, stop at t=38.
    initial begin
        int mst = 0;
        int t = 0;
        logic [7:0] sh = '0;
        logic [7:0] e;
        forever begin
            @(negedge hash_clk);
            if (reset) mst = 0;
            else if (mst == 0) begin
                if (tx_serial == 1'b0) begin
                    mst = 1;
                    t = 0;
                end
            end else begin
                t++;
                if (t == 2 && tx_serial !== 1'b0) begin
                    chk("start_bit", {31'b0, tx_serial}, 32'd0);
                    mst = 0;
                end else if (t >= 6 && t <= 34 && (t - 6) % 4 == 0) begin
                    sh[(t - 6) / 4] = tx_serial;
                end else if (t == 38) begin
                    chk("stop_bit", {31'b0, tx_serial}, 32'd1);
                    if (exp_q.size() == 0) chk("unexpected_byte", {24'b0, sh}, 32'hffff_ffff);
                    else begin
                        e = exp_q.pop_front();
                        chk("rx_byte", {24'b0, sh}, {24'b0, e});
                    end
                    mst = 0;
                end
            end
        end
    end

    initial begin
        int peak;
        bit ok;
        repeat (3) tick();
        chk("rst_tx", {31'b0, tx_serial}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_ovf", {31'b0, overflow}, 32'd0);
        chk("rst_cnt", {29'b0, fifo_count}, 32'd0);
        reset = 1'b0;
        repeat (7) tick();

        // single nonce: strobe at edge N
        strobe(32'h12345678, 1);
        chk("single_cnt_n", {29'b0, fifo_count}, 32'd1);
        chk("single_tx_n", {31'b0, tx_serial}, 32'd1);
        tick();
        chk("single_tx_n1", {31'b0, tx_serial}, 32'd0);
        chk("single_cnt_n1", {29'b0, fifo_count}, 32'd0);
        repeat (159) tick();
        chk("single_busy_n160", {31'b0, busy}, 32'd1);
        tick();
        chk("single_busy_n161", {31'b0, busy}, 32'd0);
        chk("single_tx_n161", {31'b0, tx_serial}, 32'd1);
        ok = 1;
        repeat (10) begin
            tick();
            if (tx_serial !== 1'b1 || busy !== 1'b0) ok = 0;
        end
        chk("single_idle_after", {31'b0, ok}, 32'd1);
        chk("single_leftover", exp_q.size(), 32'd0);

        // back-to-back
        strobe(32'hAABBCCDD, 1);
        peak = fifo_count;
        strobe(32'h00000001, 1);
        chk("b2b_tx_n1", {31'b0, tx_serial}, 32'd0);
        repeat (159) begin
            if (fifo_count > peak) peak = fifo_count;
            tick();
        end
        chk("b2b_peak", peak, 32'd1);
        tick();
        chk("b2b_idle_tx", {31'b0, tx_serial}, 32'd1);
        chk("b2b_idle_cnt", {29'b0, fifo_count}, 32'd1);
        tick();
        chk("b2b_second_start", {31'b0, tx_serial}, 32'd0);
        chk("b2b_cnt_after_pop", {29'b0, fifo_count}, 32'd0);
        wait_drain("b2b");
        chk("b2b_ovf", {31'b0, overflow}, 32'd0);

        // overflow
        rst_dut();
        for (int i = 1; i <= 6; i++) begin
            strobe(i, i <= 5);
            if (i == 5) begin
                chk("ovf_cnt_full", {29'b0, fifo_count}, 32'd4);
                chk("ovf_before", {31'b0, overflow}, 32'd0);
            end
        end
        chk("ovf_set", {31'b0, overflow}, 32'd1);
        chk("ovf_cnt", {29'b0, fifo_count}, 32'd4);
        wait_drain("ovf");
        chk("ovf_sticky", {31'b0, overflow}, 32'd1);
        chk("ovf_cnt_drained", {29'b0, fifo_count}, 32'd0);

        // full push + pop on the IDLE pop edge
        rst_dut();
        strobe(32'h01020304, 1);
        strobe(32'h05060708, 1);
        strobe(32'h090A0B0C, 1);
        strobe(32'h0D0E0F10, 1);
        strobe(32'h11121314, 1);
        chk("fpp_full", {29'b0, fifo_count}, 32'd4);
        repeat (157) tick();
        chk("fpp_idle_tx", {31'b0, tx_serial}, 32'd1);
        chk("fpp_idle_cnt", {29'b0, fifo_count}, 32'd4);
        strobe(32'h0BADF00D, 1);
        chk("fpp_cnt", {29'b0, fifo_count}, 32'd4);
        chk("fpp_ovf", {31'b0, overflow}, 32'd0);
        chk("fpp_start", {31'b0, tx_serial}, 32'd0);
        wait_drain("fpp");
        chk("fpp_ovf_end", {31'b0, overflow}, 32'd0);

        // reset during byte 2 data bit 3
        rst_dut();
        strobe(32'h11223344, 1);
        strobe(32'h55667788, 1);
        repeat (96) tick();
        chk("mid_pre_tx", {31'b0, tx_serial}, 32'd0);
        chk("mid_pre_cnt", {29'b0, fifo_count}, 32'd1);
        chk("mid_bytes_done", exp_q.size(), 32'd6);
        reset = 1'b1;
        exp_q.delete();
        tick();
        chk("mid_rst_tx", {31'b0, tx_serial}, 32'd1);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_cnt", {29'b0, fifo_count}, 32'd0);
        chk("mid_rst_ovf", {31'b0, overflow}, 32'd0);
        reset = 1'b0;
        tick();
        strobe(32'hCAFEBABE, 1);
        wait_drain("mid_new");

        // idle stability
        rst_dut();
        ok = 1;
        repeat (1000) begin
            tick();
            if (tx_serial !== 1'b1 || busy !== 1'b0) ok = 0;
        end
        chk("idle_stable", {31'b0, ok}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
